// File: rtl/vbuff_pkg.sv
// Shared types and helpers for the two-bank video buffer scheduler.
package vbuff_pkg;

    typedef enum logic {EMPTY, RUN} sched_state_t;

    typedef logic bank_t;

    function automatic int FRAME_PIXELS(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/vbuff_bank_scheduler_sat_counter.sv
// Saturating event counter: counts inc_i pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            cnt_o <= '0;
        else if (inc_i && (cnt_o != {W{1'b1}}))
            cnt_o <= cnt_o + 1'b1;
    end

endmodule

// File: rtl/vbuff_bank_scheduler.sv
// Ping-pong bank scheduler between a frame writer and a frame reader,
// tracking dropped (overwritten) and repeated (replayed) frames.
module vbuff_bank_scheduler
    import vbuff_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CNT_W  = 16
) (
    input  logic                                pclk,
    input  logic                                rst_n,
    input  logic                                wr_frame_done_i,
    input  logic                                rd_frame_done_i,
    output logic                                wr_bank_o,
    output logic                                rd_bank_o,
    output logic [$clog2(2*WIDTH*HEIGHT)-1:0]   wr_base_o,
    output logic [$clog2(2*WIDTH*HEIGHT)-1:0]   rd_base_o,
    output logic                                rd_frame_avail_o,
    output logic                                pending_o,
    output logic [CNT_W-1:0]                    drop_cnt_o,
    output logic [CNT_W-1:0]                    repeat_cnt_o
);

    localparam int FP = FRAME_PIXELS(WIDTH, HEIGHT);
    localparam int AW = $clog2(2 * WIDTH * HEIGHT);

    sched_state_t state, next_state;
    bank_t        wr_bank, rd_bank;

    logic swap;
    logic set_pending;
    logic clr_pending;
    logic set_avail;
    logic drop_inc;
    logic repeat_inc;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (wr_frame_done_i) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = EMPTY;
        endcase
    end

    // A simultaneous wr/rd pulse hands the just-finished frame straight over.
    always_comb begin
        swap        = 1'b0;
        set_pending = 1'b0;
        clr_pending = 1'b0;
        set_avail   = 1'b0;
        drop_inc    = 1'b0;
        repeat_inc  = 1'b0;
        case (state)
            EMPTY: begin
                if (wr_frame_done_i) begin
                    swap      = 1'b1;
                    set_avail = 1'b1;
                end
            end
            RUN: begin
                if (wr_frame_done_i && rd_frame_done_i) begin
                    swap        = 1'b1;
                    clr_pending = 1'b1;
                    drop_inc    = pending_o;
                end else if (wr_frame_done_i) begin
                    set_pending = 1'b1;
                    drop_inc    = pending_o;
                end else if (rd_frame_done_i) begin
                    swap        = pending_o;
                    clr_pending = pending_o;
                    repeat_inc  = ~pending_o;
                end
            end
            default: ;
        endcase
    end

    // Both bank flops toggle together so they can never be equal.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank          <= 1'b0;
            rd_bank          <= 1'b1;
            pending_o        <= 1'b0;
            rd_frame_avail_o <= 1'b0;
        end else begin
            if (swap) begin
                wr_bank <= ~wr_bank;
                rd_bank <= ~rd_bank;
            end
            if (clr_pending)
                pending_o <= 1'b0;
            else if (set_pending)
                pending_o <= 1'b1;
            if (set_avail)
                rd_frame_avail_o <= 1'b1;
        end
    end

    assign wr_bank_o = wr_bank;
    assign rd_bank_o = rd_bank;
    assign wr_base_o = wr_bank ? AW'(FP) : '0;
    assign rd_base_o = rd_bank ? AW'(FP) : '0;

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .pclk  (pclk),
        .rst_n (rst_n),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_repeat_cnt (
        .pclk  (pclk),
        .rst_n (rst_n),
        .inc_i (repeat_inc),
        .cnt_o (repeat_cnt_o)
    );

endmodule

// File: tb/tb_vbuff_bank_scheduler.sv
// Self-checking bench for vbuff_bank_scheduler: directed scenarios followed
// by random pulse traffic, compared against a frame-level reference model.
module tb_vbuff_bank_scheduler;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int CNT_W  = 2;
    localparam int FP     = WIDTH * HEIGHT;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             pclk;
    logic             rst_n;
    logic             wr_frame_done_i;
    logic             rd_frame_done_i;
    logic             wr_bank_o;
    logic             rd_bank_o;
    logic [3:0]       wr_base_o;
    logic [3:0]       rd_base_o;
    logic             rd_frame_avail_o;
    logic             pending_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic [CNT_W-1:0] repeat_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: which bank the reader owns and frame bookkeeping.
    int m_rd_bank;
    int m_have_frame;
    int m_pending;
    int m_drops;
    int m_repeats;

    vbuff_bank_scheduler #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .CNT_W  (CNT_W)
    ) dut (
        .pclk             (pclk),
        .rst_n            (rst_n),
        .wr_frame_done_i  (wr_frame_done_i),
        .rd_frame_done_i  (rd_frame_done_i),
        .wr_bank_o        (wr_bank_o),
        .rd_bank_o        (rd_bank_o),
        .wr_base_o        (wr_base_o),
        .rd_base_o        (rd_base_o),
        .rd_frame_avail_o (rd_frame_avail_o),
        .pending_o        (pending_o),
        .drop_cnt_o       (drop_cnt_o),
        .repeat_cnt_o     (repeat_cnt_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int sat_add(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic model_reset();
        m_rd_bank    = 1;
        m_have_frame = 0;
        m_pending    = 0;
        m_drops      = 0;
        m_repeats    = 0;
    endtask

    // One clock of frame-level behaviour: a finished write either goes to
    // the reader immediately, waits as pending, or overwrites a waiting frame.
    task automatic model_step(input bit wr, input bit rd);
        if (m_have_frame == 0) begin
            if (wr) begin
                m_rd_bank    = 1 - m_rd_bank;
                m_have_frame = 1;
            end
        end else if (wr && rd) begin
            if (m_pending != 0) m_drops = sat_add(m_drops);
            m_rd_bank = 1 - m_rd_bank;
            m_pending = 0;
        end else if (wr) begin
            if (m_pending != 0) m_drops = sat_add(m_drops);
            m_pending = 1;
        end else if (rd) begin
            if (m_pending != 0) begin
                m_rd_bank = 1 - m_rd_bank;
                m_pending = 0;
            end else begin
                m_repeats = sat_add(m_repeats);
            end
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".wr_bank"},  32'(wr_bank_o),        32'(1 - m_rd_bank));
        check_output({tag, ".rd_bank"},  32'(rd_bank_o),        32'(m_rd_bank));
        check_output({tag, ".wr_base"},  32'(wr_base_o),        32'((1 - m_rd_bank) * FP));
        check_output({tag, ".rd_base"},  32'(rd_base_o),        32'(m_rd_bank * FP));
        check_output({tag, ".avail"},    32'(rd_frame_avail_o), 32'(m_have_frame));
        check_output({tag, ".pending"},  32'(pending_o),        32'(m_pending));
        check_output({tag, ".drop"},     32'(drop_cnt_o),       32'(m_drops));
        check_output({tag, ".repeat"},   32'(repeat_cnt_o),     32'(m_repeats));
    endtask

    // Drive pulses for one cycle, let the DUT and model take the edge, check.
    task automatic apply_stimulus(input bit wr, input bit rd, input string tag);
        wr_frame_done_i = wr;
        rd_frame_done_i = rd;
        @(posedge pclk);
        model_step(wr, rd);
        #1;
        wr_frame_done_i = 1'b0;
        rd_frame_done_i = 1'b0;
        check_all(tag);
    endtask

    task automatic assert_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n           = 1'b1;
        wr_frame_done_i = 1'b0;
        rd_frame_done_i = 1'b0;
        model_reset();

        // Power-up reset, checked before any clock edge.
        #2;
        assert_reset("reset_async");
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;

        // Idle after release: nothing changes.
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0, "idle");

        // First write from EMPTY hands the frame to the reader.
        apply_stimulus(1'b1, 1'b0, "first_wr");

        // Write, gap, then read consumes the pending frame.
        apply_stimulus(1'b1, 1'b0, "wr_pend");
        apply_stimulus(1'b0, 1'b0, "gap");
        apply_stimulus(1'b0, 1'b0, "gap");
        apply_stimulus(1'b0, 1'b1, "rd_swap");

        // Three writes with no read: two drops; then one swap and one replay.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, "wr_drop");
        apply_stimulus(1'b0, 1'b1, "rd_after_drop");
        apply_stimulus(1'b0, 1'b1, "rd_repeat");

        // Simultaneous pulses with nothing pending.
        apply_stimulus(1'b1, 1'b1, "both_nopend");

        // Simultaneous pulses with a frame already pending.
        apply_stimulus(1'b1, 1'b0, "wr_pend2");
        apply_stimulus(1'b1, 1'b1, "both_pend");

        // Reads in EMPTY are ignored.
        assert_reset("reset_mid");
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, "empty_rd");
        apply_stimulus(1'b0, 1'b1, "empty_rd");

        // Write pulse in the same cycle reset releases is honoured.
        rst_n = 1'b0;
        model_reset();
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, "wr_at_release");

        // Five replays saturate the 2-bit repeat counter.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, "replay_sat");

        // Reset mid-sequence, away from any clock edge.
        #2;
        assert_reset("reset_async_mid");
        @(posedge pclk);
        #1;
        rst_n = 1'b1;

        // Random pulse traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                assert_reset("rand_reset");
                @(posedge pclk);
                #1;
                rst_n = 1'b1;
            end
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
